// File: rtl/crc16_check_d128_pkg.sv
`default_nettype none
// ============================================================================
// Module      : crc16_pkg
// Description : CRC-16 (0x8005, MSB-first, unreflected) constants, the shared
//               128-bit parallel step function and the status record type.
// Revision    : 1.0 - initial release
// ============================================================================
package crc16_pkg;

    localparam int              CRC16_W    = 16;
    localparam logic [15:0]     CRC16_POLY = 16'h8005;
    localparam int              ST_BEATS_W = 16;

    typedef struct packed {
        logic                   ok;
        logic                   len_err;
        logic [CRC16_W-1:0]     crc;
        logic [ST_BEATS_W-1:0]  beats;
    } crc_st_t;

    // Bit 127 enters the register first; the loop unrolls into XOR trees.
    function automatic logic [CRC16_W-1:0] crc16_d128_next(
        input logic [127:0]         data,
        input logic [CRC16_W-1:0]   crc
    );
        logic [CRC16_W-1:0] c;
        logic               fb;
        c = crc;
        for (int i = 127; i >= 0; i--) begin
            fb = c[CRC16_W-1] ^ data[i];
            c  = {c[CRC16_W-2:0], 1'b0};
            if (fb) begin
                c = c ^ CRC16_POLY;
            end
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/crc16_check_d128.sv
`default_nettype none
// ============================================================================
// Module      : crc16_check_d128
// Description : Streaming CRC-16 checker for 128-bit beats; emits one status
//               record per packet over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module crc16_check_d128
    import crc16_pkg::*;
#(
    parameter logic [15:0] CRC_INIT  = 16'h0000,
    parameter int          MAX_BEATS = 256
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [127:0]                    in_data,
    input  logic                            in_sop,
    input  logic                            in_eop,
    input  logic [15:0]                     in_crc,
    output logic                            st_valid,
    input  logic                            st_ready,
    output logic                            st_ok,
    output logic                            st_len_err,
    output logic [15:0]                     st_crc,
    output logic [$clog2(MAX_BEATS+1):0]    st_beats,
    output logic [15:0]                     orphan_cnt
);

    localparam int                 BEATS_W     = $clog2(MAX_BEATS + 1) + 1;
    localparam logic [BEATS_W-1:0] c_BEATS_SAT = '1;
    localparam logic [BEATS_W-1:0] c_MAX_BEATS = BEATS_W'(MAX_BEATS);
    localparam logic [BEATS_W-1:0] c_BEATS_ONE = BEATS_W'(1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_BODY   = 2'd1;
    localparam logic [1:0] c_STATUS = 2'd2;

    logic [1:0]          r_state;
    logic [15:0]         r_acc;
    logic [BEATS_W-1:0]  r_beats;
    logic                r_st_ok;
    logic                r_st_len_err;
    logic [15:0]         r_st_crc;
    logic [BEATS_W-1:0]  r_st_beats;
    logic [15:0]         r_orphan;

    logic                w_accept;
    logic                w_take;
    logic                w_orphan;
    logic [15:0]         w_seed;
    logic [15:0]         w_crc_next;
    logic [BEATS_W-1:0]  w_beats_base;
    logic [BEATS_W-1:0]  w_beats_next;
    logic                w_len_err;

    // Ready is a pure state decode, forced low while reset is held.
    assign in_ready   = rst_n && (r_state != c_STATUS);
    assign st_valid   = (r_state == c_STATUS);
    assign st_ok      = r_st_ok;
    assign st_len_err = r_st_len_err;
    assign st_crc     = r_st_crc;
    assign st_beats   = r_st_beats;
    assign orphan_cnt = r_orphan;

    always_comb begin
        w_accept     = in_valid && in_ready;
        // A beat joins a packet if it opens one or continues an open one.
        w_take       = w_accept && (in_sop || (r_state == c_BODY));
        // Stray continuation beats in IDLE and SOP restarts inside BODY.
        w_orphan     = w_accept && (in_sop ? (r_state == c_BODY) : (r_state == c_IDLE));
        w_seed       = in_sop ? CRC_INIT : r_acc;
        w_crc_next   = crc16_d128_next(in_data, w_seed);
        w_beats_base = in_sop ? '0 : r_beats;
        w_beats_next = (w_beats_base == c_BEATS_SAT) ? c_BEATS_SAT
                                                     : w_beats_base + c_BEATS_ONE;
        w_len_err    = (w_beats_next > c_MAX_BEATS);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_acc        <= CRC_INIT;
            r_beats      <= '0;
            r_st_ok      <= 1'b0;
            r_st_len_err <= 1'b0;
            r_st_crc     <= '0;
            r_st_beats   <= '0;
            r_orphan     <= '0;
        end else begin
            if (w_orphan && (r_orphan != 16'hFFFF)) begin
                r_orphan <= r_orphan + 16'd1;
            end

            case (r_state)
                c_IDLE, c_BODY: begin
                    if (w_take) begin
                        if (in_eop) begin
                            r_st_crc     <= w_crc_next;
                            r_st_beats   <= w_beats_next;
                            r_st_len_err <= w_len_err;
                            r_st_ok      <= (w_crc_next == in_crc) && !w_len_err;
                            r_acc        <= CRC_INIT;
                            r_beats      <= '0;
                            r_state      <= c_STATUS;
                        end else begin
                            r_acc        <= w_crc_next;
                            r_beats      <= w_beats_next;
                            r_state      <= c_BODY;
                        end
                    end
                end
                c_STATUS: begin
                    if (st_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_crc16_check_d128.sv
`default_nettype none
// ============================================================================
// Module      : tb_crc16_check_d128
// Description : Scoreboard bench for crc16_check_d128 with a bit-serial
//               polynomial-division reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crc16_check_d128;
    import crc16_pkg::*;

    localparam int MAX_BEATS = 4;
    localparam int BW        = $clog2(MAX_BEATS + 1) + 1;
    localparam int BEATS_SAT = (1 << BW) - 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [127:0]   in_data = '0;
    logic           in_sop = 1'b0;
    logic           in_eop = 1'b0;
    logic [15:0]    in_crc = '0;
    logic           st_valid;
    logic           st_ready = 1'b1;
    logic           st_ok;
    logic           st_len_err;
    logic [15:0]    st_crc;
    logic [BW-1:0]  st_beats;
    logic [15:0]    orphan_cnt;

    int checks = 0;
    int errors = 0;
    int rdy_mode = 0;   // 0: st_ready high, 1: st_ready low, 2: random

    crc_st_t        exp_q[$];
    logic [127:0]   cur_pkt[$];
    bit             in_pkt = 0;
    int             orphan_m = 0;

    crc16_check_d128 #(
        .CRC_INIT  (16'h0000),
        .MAX_BEATS (MAX_BEATS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sop     (in_sop),
        .in_eop     (in_eop),
        .in_crc     (in_crc),
        .st_valid   (st_valid),
        .st_ready   (st_ready),
        .st_ok      (st_ok),
        .st_len_err (st_len_err),
        .st_crc     (st_crc),
        .st_beats   (st_beats),
        .orphan_cnt (orphan_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Remainder of (message * x^16) / (x^16 + x^15 + x^2 + 1), seed folded into the head.
    function automatic logic [15:0] ref_crc(input logic [127:0] pkt[$]);
        bit          bits[$];
        logic [16:0] rem;
        foreach (pkt[b]) begin
            for (int i = 127; i >= 0; i--) bits.push_back(pkt[b][i]);
        end
        for (int i = 0; i < 16; i++) bits.push_back(1'b0);
        rem = '0;
        foreach (bits[k]) begin
            rem = {rem[15:0], bits[k]};
            if (rem[16]) rem = rem ^ 17'h18005;
        end
        return rem[15:0];
    endfunction

    task automatic model_accept(input logic [127:0] d, input logic sop, input logic eop,
                                input logic [15:0] c, output bit produced);
        crc_st_t s;
        int      n;
        produced = 0;
        if (sop) begin
            if (in_pkt && orphan_m < 65535) orphan_m++;
            cur_pkt.delete();
            in_pkt = 1;
        end else if (!in_pkt) begin
            if (orphan_m < 65535) orphan_m++;
            return;
        end
        cur_pkt.push_back(d);
        if (eop) begin
            n         = cur_pkt.size();
            s.crc     = ref_crc(cur_pkt);
            s.len_err = (n > MAX_BEATS);
            s.beats   = 16'((n > BEATS_SAT) ? BEATS_SAT : n);
            s.ok      = (s.crc == c) && !s.len_err;
            exp_q.push_back(s);
            in_pkt    = 0;
            produced  = 1;
        end
    endtask

    task automatic send_beat(input logic [127:0] d, input logic sop, input logic eop,
                             input logic [15:0] c);
        int guard;
        bit produced;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_sop = sop; in_eop = eop; in_crc = c;
        #1;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk); #1;
            guard++;
        end
        if (!in_ready) begin
            check("ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_accept(d, sop, eop, c, produced);
        if (produced) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            check("eop_latency_valid", 32'(st_valid), 32'd1);
            check("status_in_ready_low", 32'(in_ready), 32'd0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = rand128();
            in_sop   = 1'($urandom_range(0, 1));
            in_eop   = 1'($urandom_range(0, 1));
            in_crc   = 16'($urandom());
        end
    endtask

    task automatic send_pkt(input logic [127:0] beats[$], input logic [15:0] c);
        foreach (beats[i]) send_beat(beats[i], i == 0, i == beats.size() - 1, c);
    endtask

    task automatic do_reset(input bit check_outputs);
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        cur_pkt.delete();
        in_pkt = 0;
        orphan_m = 0;
        #1;
        check("reset_in_ready_low", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        if (check_outputs) begin
            check("reset_st_valid",   32'(st_valid),   32'd0);
            check("reset_st_ok",      32'(st_ok),      32'd0);
            check("reset_st_len_err", 32'(st_len_err), 32'd0);
            check("reset_st_crc",     32'(st_crc),     32'd0);
            check("reset_st_beats",   32'(st_beats),   32'd0);
            check("reset_orphan_cnt", 32'(orphan_cnt), 32'd0);
        end
        rst_n = 1'b1;
    endtask

    // st_ready driver
    initial begin
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       st_ready = 1'b1;
                1:       st_ready = 1'b0;
                default: st_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on each status handshake, checks hold/bubble rules.
    initial begin
        bit          prev_v, prev_hs, hs;
        logic [31:0] prev_fields;
        crc_st_t     e;
        prev_v = 0; prev_hs = 0; prev_fields = '0;
        forever begin
            @(negedge clk); #1;
            if (!rst_n) begin
                prev_v = 0; prev_hs = 0;
            end else begin
                if (prev_v && !prev_hs) begin
                    check("st_valid_held", 32'(st_valid), 32'd1);
                    check("st_fields_stable", {12'(st_beats), st_crc, st_len_err, st_ok}, prev_fields);
                end
                if (prev_hs) check("bubble_in_ready", 32'(in_ready), 32'd1);
                hs = st_valid && st_ready;
                if (hs) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_status", 32'(st_valid), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("st_crc",     32'(st_crc),     32'(e.crc));
                        check("st_ok",      32'(st_ok),      32'(e.ok));
                        check("st_len_err", 32'(st_len_err), 32'(e.len_err));
                        check("st_beats",   32'(st_beats),   32'(e.beats));
                    end
                end
                prev_v = st_valid; prev_hs = hs;
                prev_fields = {12'(st_beats), st_crc, st_len_err, st_ok};
            end
        end
    end

    initial begin
        logic [127:0] pkt[$];
        logic [15:0]  good;
        int           n;

        do_reset(1);
        idle(2);

        // single beat, zero data
        pkt.delete(); pkt.push_back(128'h0);
        send_pkt(pkt, 16'h0000);
        // single beat 1 with wrong then right CRC
        pkt.delete(); pkt.push_back(128'h1);
        send_pkt(pkt, 16'h0001);
        send_pkt(pkt, 16'h8005);
        // two beats
        pkt.delete(); pkt.push_back(128'h0); pkt.push_back(128'h1);
        send_pkt(pkt, 16'h8005);

        // backpressure on the status port
        rdy_mode = 1;
        pkt.delete(); pkt.push_back(rand128());
        send_pkt(pkt, 16'($urandom()));
        repeat (5) begin
            @(negedge clk); #1;
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            check("bp_st_valid",     32'(st_valid), 32'd1);
        end
        rdy_mode = 0;
        idle(3);

        // orphans, then SOP restart
        send_beat(rand128(), 1'b0, 1'b0, 16'h0);
        send_beat(rand128(), 1'b0, 1'b1, 16'h0);
        idle(2); #1;
        check("orphan_cnt_idle", 32'(orphan_cnt), 32'(orphan_m));
        send_beat(rand128(), 1'b1, 1'b0, 16'h0);
        pkt.delete(); pkt.push_back(rand128()); pkt.push_back(rand128());
        send_pkt(pkt, ref_crc(pkt));
        idle(2); #1;
        check("orphan_cnt_restart", 32'(orphan_cnt), 32'(orphan_m));

        // exactly MAX_BEATS, one over, and far over (st_beats saturation)
        foreach (pkt[i]) pkt[i] = '0;
        pkt.delete(); repeat (MAX_BEATS) pkt.push_back(128'h0);
        send_pkt(pkt, 16'h0000);
        pkt.push_back(128'h0);
        send_pkt(pkt, 16'h0000);
        pkt.delete(); repeat (BEATS_SAT + 2) pkt.push_back(rand128());
        send_pkt(pkt, ref_crc(pkt));

        // randomized traffic with random status backpressure
        rdy_mode = 2;
        for (int p = 0; p < 60; p++) begin
            if ($urandom_range(0, 9) == 0)
                send_beat(rand128(), 1'b0, 1'($urandom_range(0, 1)), 16'($urandom()));
            if ($urandom_range(0, 9) == 0) begin
                send_beat(rand128(), 1'b1, 1'b0, 16'($urandom()));
                if ($urandom_range(0, 1) == 1) send_beat(rand128(), 1'b0, 1'b0, 16'($urandom()));
            end
            n = ($urandom_range(0, 7) == 0) ? $urandom_range(MAX_BEATS + 1, MAX_BEATS + 3)
                                             : $urandom_range(1, MAX_BEATS);
            pkt.delete();
            for (int i = 0; i < n; i++) pkt.push_back(rand128());
            good = ref_crc(pkt);
            if ($urandom_range(0, 1) == 1) good = good ^ 16'($urandom_range(1, 65535));
            send_pkt(pkt, good);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rdy_mode = 0;
        idle(5); #1;
        check("orphan_cnt_random", 32'(orphan_cnt), 32'(orphan_m));

        // reset in the middle of a packet
        send_beat(rand128(), 1'b1, 1'b0, 16'h0);
        send_beat(rand128(), 1'b0, 1'b0, 16'h0);
        do_reset(1);
        idle(6);
        #1;
        check("post_reset_no_status", 32'(st_valid), 32'd0);

        // drain check
        for (int w = 0; w < 50 && exp_q.size() != 0; w++) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
